tx_sb_req_resp_ctrl: RTL and testbench
======================================

Name: tx_sb_req_resp_ctrl

Overview:
- Parametrised TX-side sideband request/response engine for LTSM substates (PHYRETRAIN, and future TRAINERROR/L1 entry handshakes).
- When enabled, it sends a configurable REQ message with an info field, waits for the partner's RESP, and reports done.
- It generalises the fixed PHYRETRAIN TX controller with parametrised message codes and info width, a caller-supplied info field, a response timeout with error reporting, and collision handling when the partner's REQ arrives first.
- It sits between the LTSM substate controller and the SB wrapper/encoder.

Parameters:
- SB_MSG_WIDTH, 4, width of encoded/decoded SB message codes.
- INFO_WIDTH, 3, width of the message-info field.
- REQ_CODE, 1, encoded SB code of the request message.
- RESP_CODE, 2, encoded SB code of the response message.
- TIMEOUT_CYCLES, 1024, cycles allowed in WAIT_RX+SEND_REQ before timeout (≥2).
- TMR_WIDTH, 16, timeout counter width; must hold TIMEOUT_CYCLES-1.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_en  input  1  substate enable from LTSM; level, held for the whole substate.
- i_msg_info  input  INFO_WIDTH  info to send with REQ; sampled on the REQ launch edge.
- i_falling_edge_busy  input  1  one-cycle pulse from SB: current transmission finished.
- i_rx_valid  input  1  partner RX controller currently owns the SB transmitter.
- i_decoded_SB_msg  input  SB_MSG_WIDTH  decoded received SB message.
- i_rx_msg_valid  input  1  i_decoded_SB_msg valid this cycle.
- o_encoded_SB_msg_tx  output  SB_MSG_WIDTH  message code to transmit.
- o_msg_info  output  INFO_WIDTH  info field to transmit.
- o_valid_tx  output  1  request to wrapper to transmit o_encoded_SB_msg_tx.
- o_done  output  1  handshake complete; level until i_en deasserts.
- o_timeout  output  1  no RESP within TIMEOUT_CYCLES; level until i_en deasserts.

Behaviour:
- Reset (async) sets CS=IDLE, the timer to 0, and all outputs to 0.
- All outputs are registered and update on the same edge CS enters the new state. The next state is combinational from CS and inputs.
- Let partner_req = i_rx_msg_valid && i_decoded_SB_msg==REQ_CODE, and resp = i_rx_msg_valid && i_decoded_SB_msg==RESP_CODE.

States:
- IDLE:
  - Outputs are held at 0.
  - i_en && partner_req -> WAIT_RX.
  - Otherwise i_en -> SEND_REQ (launch).
  - Otherwise stay.
- WAIT_RX:
  - The partner REQ is being answered by our RX block.
  - i_falling_edge_busy && i_rx_valid -> SEND_REQ (launch).
- SEND_REQ:
  - resp -> DONE.
  - Any other received message, including partner_req, is ignored.
- DONE:
  - o_done=1, o_valid_tx=0.
  - Holds until i_en=0.
- TIMEOUT:
  - o_timeout=1, o_valid_tx=0, o_done=0.
  - Holds until i_en=0.

Launch edge (entry to SEND_REQ from IDLE or WAIT_RX):
- o_encoded_SB_msg_tx <= REQ_CODE.
- o_msg_info <= i_msg_info.
- o_valid_tx <= 1.

o_valid_tx clear:
- Clears when i_falling_edge_busy && !i_rx_valid (our message sent). This is the only clear besides exit, DONE or TIMEOUT.
- A busy falling edge with i_rx_valid=1 does not clear it.
- o_encoded_SB_msg_tx and o_msg_info hold after valid clears, until IDLE.

Timer:
- Cleared in IDLE.
- Increments each cycle CS is WAIT_RX or SEND_REQ; it does not reset on the WAIT_RX->SEND_REQ transition.
- When timer==TIMEOUT_CYCLES-1 and no exit condition fires that cycle, the next state is TIMEOUT.
- If resp (in SEND_REQ) or the launch condition (in WAIT_RX) fires in the same cycle, that transition wins over TIMEOUT.
- The timer saturates in DONE and TIMEOUT.

i_en deasserted:
- From any state, next state is IDLE.
- Next edge clears o_valid_tx, o_done, o_timeout, o_encoded_SB_msg_tx, o_msg_info and the timer.
- i_en low has priority over every other condition.

Other boundary rules:
- i_rx_msg_valid=0 ignores i_decoded_SB_msg entirely.
- A RESP received in IDLE or WAIT_RX is ignored.
- Re-asserting i_en after IDLE starts a fresh handshake.
- Illegal CS goes to IDLE.

Test Plan:
- Nominal handshake, TIMEOUT_CYCLES=16, i_msg_info=3'b100:
  - i_en=1 -> next edge o_valid_tx=1, o_encoded=1, o_msg_info=3'b100.
  - busy pulse with rx_valid=0 -> o_valid_tx=0.
  - RESP(2) with rx_msg_valid -> o_done=1 next edge.
  - o_timeout stays 0.
- Collision:
  - i_en=1 and partner REQ(1) valid in the same cycle -> WAIT_RX, o_valid_tx=0.
  - busy pulse with rx_valid=0 -> stays in WAIT_RX.
  - busy pulse with rx_valid=1 -> o_valid_tx=1, o_encoded=1.
  - RESP -> o_done=1.
- Timeout, TIMEOUT_CYCLES=16:
  - Launch, then no RESP -> o_timeout=1 exactly 16 edges after entering SEND_REQ, o_valid_tx=0, o_done=0.
  - i_en=0 -> all outputs 0 next edge.
- Race at expiry: RESP valid in the cycle timer==15 -> o_done=1, o_timeout=0.
- Abort and restart:
  - i_en dropped mid-SEND_REQ with o_valid_tx=1 -> next edge o_valid_tx=0, o_encoded=0.
  - i_en raised again with i_msg_info=3'b001 -> fresh launch with o_msg_info=3'b001 and timer restarted from 0.
- Noise and reset:
  - RESP code with rx_msg_valid=0, and partner REQ(1) while in SEND_REQ -> no state change.
  - Async reset asserted mid-handshake -> all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/tx_sb_req_resp_ctrl.sv
// TX-side sideband REQ/RESP handshake engine for LTSM substates.
// Sends REQ (+info), waits for RESP, with collision deferral and response timeout.
module tx_sb_req_resp_ctrl #(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int INFO_WIDTH     = 3,
  parameter int REQ_CODE       = 1,
  parameter int RESP_CODE      = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TMR_WIDTH      = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic [INFO_WIDTH-1:0]   i_msg_info,
  input  logic                    i_falling_edge_busy,
  input  logic                    i_rx_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
  input  logic                    i_rx_msg_valid,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_tx,
  output logic [INFO_WIDTH-1:0]   o_msg_info,
  output logic                    o_valid_tx,
  output logic                    o_done,
  output logic                    o_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RX, S_SEND_REQ, S_DONE, S_TIMEOUT
  } state_t;

  state_t               cs, ns;
  logic [TMR_WIDTH-1:0] timer;
  logic                 partner_req, resp, tmr_exp, launch, rx_turn;

  assign partner_req = i_rx_msg_valid && (i_decoded_SB_msg == SB_MSG_WIDTH'(REQ_CODE));
  assign resp        = i_rx_msg_valid && (i_decoded_SB_msg == SB_MSG_WIDTH'(RESP_CODE));
  assign tmr_exp     = (timer == TMR_WIDTH'(TIMEOUT_CYCLES - 1));
  // Partner's answer to its own REQ just left the wire: our turn to send.
  assign rx_turn     = i_falling_edge_busy && i_rx_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cs <= S_IDLE;
    else          cs <= ns;
  end

  // Exit conditions are checked before expiry so a same-cycle RESP/launch wins.
  always_comb begin
    ns = cs;
    if (!i_en) ns = S_IDLE;
    else begin
      case (cs)
        S_IDLE:     ns = partner_req ? S_WAIT_RX : S_SEND_REQ;
        S_WAIT_RX:  if (rx_turn) ns = S_SEND_REQ;
                    else if (tmr_exp) ns = S_TIMEOUT;
        S_SEND_REQ: if (resp) ns = S_DONE;
                    else if (tmr_exp) ns = S_TIMEOUT;
        S_DONE:     ns = S_DONE;
        S_TIMEOUT:  ns = S_TIMEOUT;
        default:    ns = S_IDLE;
      endcase
    end
  end

  assign launch = ((cs == S_IDLE) || (cs == S_WAIT_RX)) && (ns == S_SEND_REQ);

  // Outputs are driven from the next state so they change on the entry edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_encoded_SB_msg_tx <= '0;
      o_msg_info          <= '0;
      o_valid_tx          <= 1'b0;
      o_done              <= 1'b0;
      o_timeout           <= 1'b0;
    end else begin
      case (ns)
        S_IDLE: begin
          o_encoded_SB_msg_tx <= '0;
          o_msg_info          <= '0;
          o_valid_tx          <= 1'b0;
          o_done              <= 1'b0;
          o_timeout           <= 1'b0;
        end
        S_SEND_REQ: begin
          if (launch) begin
            o_encoded_SB_msg_tx <= SB_MSG_WIDTH'(REQ_CODE);
            o_msg_info          <= i_msg_info;
            o_valid_tx          <= 1'b1;
          end else if (i_falling_edge_busy && !i_rx_valid) begin
            o_valid_tx <= 1'b0;
          end
        end
        S_DONE: begin
          o_valid_tx <= 1'b0;
          o_done     <= 1'b1;
          o_timeout  <= 1'b0;
        end
        S_TIMEOUT: begin
          o_valid_tx <= 1'b0;
          o_done     <= 1'b0;
          o_timeout  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Runs across WAIT_RX and SEND_REQ without restarting; frozen in DONE/TIMEOUT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                  timer <= '0;
    else if (!i_en || cs == S_IDLE)                timer <= '0;
    else if ((cs == S_WAIT_RX || cs == S_SEND_REQ) && timer != '1)
                                                   timer <= timer + 1'b1;
  end

endmodule

// File: tb/tb_tx_sb_req_resp_ctrl.sv
// Directed bench for tx_sb_req_resp_ctrl: vector table plus timeout/race/abort/reset sequences.
module tb_tx_sb_req_resp_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_en;
  logic [2:0] i_msg_info;
  logic       i_falling_edge_busy;
  logic       i_rx_valid;
  logic [3:0] i_decoded_SB_msg;
  logic       i_rx_msg_valid;
  logic [3:0] o_encoded_SB_msg_tx;
  logic [2:0] o_msg_info;
  logic       o_valid_tx, o_done, o_timeout;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  tx_sb_req_resp_ctrl #(
    .SB_MSG_WIDTH(4), .INFO_WIDTH(3), .REQ_CODE(1), .RESP_CODE(2),
    .TIMEOUT_CYCLES(16), .TMR_WIDTH(16)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_msg_info(i_msg_info),
    .i_falling_edge_busy(i_falling_edge_busy), .i_rx_valid(i_rx_valid),
    .i_decoded_SB_msg(i_decoded_SB_msg), .i_rx_msg_valid(i_rx_msg_valid),
    .o_encoded_SB_msg_tx(o_encoded_SB_msg_tx), .o_msg_info(o_msg_info),
    .o_valid_tx(o_valid_tx), .o_done(o_done), .o_timeout(o_timeout)
  );

  // Packed output view: {valid, code[3:0], info[2:0], done, timeout}
  typedef struct {
    string      name;
    logic       en;
    logic [2:0] info;
    logic       busy;
    logic       rxv;
    logic [3:0] msg;
    logic       msgv;
    logic [9:0] exp;
  } vec_t;

  function automatic logic [9:0] ex(logic v, logic [3:0] c, logic [2:0] i, logic d, logic t);
    return {v, c, i, d, t};
  endfunction

  function automatic vec_t mk(string n, logic en, logic [2:0] info, logic busy, logic rxv,
                              logic [3:0] msg, logic msgv, logic [9:0] e);
    vec_t r;
    r.name = n; r.en = en; r.info = info; r.busy = busy; r.rxv = rxv;
    r.msg = msg; r.msgv = msgv; r.exp = e;
    return r;
  endfunction

  function automatic logic [9:0] outs();
    return {o_valid_tx, o_encoded_SB_msg_tx, o_msg_info, o_done, o_timeout};
  endfunction

  task automatic check(string n, logic [9:0] act, logic [9:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b (valid,code,info,done,timeout)", n, act, e);
    end
  endtask

  task automatic drive(logic en, logic [2:0] info, logic busy, logic rxv, logic [3:0] msg, logic msgv);
    i_en = en; i_msg_info = info; i_falling_edge_busy = busy;
    i_rx_valid = rxv; i_decoded_SB_msg = msg; i_rx_msg_valid = msgv;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = mk("idle",           0, 3'd4, 0, 0, 4'd0, 0, ex(0, 4'd0, 3'd0, 0, 0));
    vecs[1]  = mk("launch",         1, 3'd4, 0, 0, 4'd0, 0, ex(1, 4'd1, 3'd4, 0, 0));
    vecs[2]  = mk("send_hold",      1, 3'd7, 0, 0, 4'd0, 0, ex(1, 4'd1, 3'd4, 0, 0));
    vecs[3]  = mk("resp_no_valid",  1, 3'd4, 0, 0, 4'd2, 0, ex(1, 4'd1, 3'd4, 0, 0));
    vecs[4]  = mk("preq_in_send",   1, 3'd4, 0, 0, 4'd1, 1, ex(1, 4'd1, 3'd4, 0, 0));
    vecs[5]  = mk("busy_rxv_keep",  1, 3'd4, 1, 1, 4'd0, 0, ex(1, 4'd1, 3'd4, 0, 0));
    vecs[6]  = mk("busy_clear",     1, 3'd4, 1, 0, 4'd0, 0, ex(0, 4'd1, 3'd4, 0, 0));
    vecs[7]  = mk("resp_done",      1, 3'd4, 0, 0, 4'd2, 1, ex(0, 4'd1, 3'd4, 1, 0));
    vecs[8]  = mk("done_hold",      1, 3'd4, 0, 0, 4'd0, 0, ex(0, 4'd1, 3'd4, 1, 0));
    vecs[9]  = mk("en_off",         0, 3'd4, 0, 0, 4'd0, 0, ex(0, 4'd0, 3'd0, 0, 0));
    vecs[10] = mk("collide",        1, 3'd5, 0, 0, 4'd1, 1, ex(0, 4'd0, 3'd0, 0, 0));
    vecs[11] = mk("resp_in_waitrx", 1, 3'd5, 0, 0, 4'd2, 1, ex(0, 4'd0, 3'd0, 0, 0));
    vecs[12] = mk("busy_no_rxv",    1, 3'd5, 1, 0, 4'd0, 0, ex(0, 4'd0, 3'd0, 0, 0));
    vecs[13] = mk("rx_turn_launch", 1, 3'd6, 1, 1, 4'd0, 0, ex(1, 4'd1, 3'd6, 0, 0));
    vecs[14] = mk("coll_done",      1, 3'd6, 0, 0, 4'd2, 1, ex(0, 4'd1, 3'd6, 1, 0));
    vecs[15] = mk("coll_en_off",    0, 3'd6, 0, 0, 4'd0, 0, ex(0, 4'd0, 3'd0, 0, 0));

    drive(0, 0, 0, 0, 0, 0);
    i_rst_n = 1'b0;
    #1 check("reset", outs(), ex(0, 4'd0, 3'd0, 0, 0));
    #12 i_rst_n = 1'b1;
    step();

    foreach (vecs[k]) begin
      drive(vecs[k].en, vecs[k].info, vecs[k].busy, vecs[k].rxv, vecs[k].msg, vecs[k].msgv);
      step();
      check(vecs[k].name, outs(), vecs[k].exp);
    end

    // Timeout: TIMEOUT exactly 16 edges after SEND_REQ entry
    drive(1, 3'd4, 0, 0, 0, 0);
    step();
    check("to_launch", outs(), ex(1, 4'd1, 3'd4, 0, 0));
    for (int e = 1; e <= 16; e++) begin
      step();
      if (e == 15) check("to_pre_expiry", outs(), ex(1, 4'd1, 3'd4, 0, 0));
      if (e == 16) check("to_expired", outs(), ex(0, 4'd1, 3'd4, 0, 1));
    end
    step();
    check("to_hold", outs(), ex(0, 4'd1, 3'd4, 0, 1));
    drive(0, 3'd4, 0, 0, 0, 0);
    step();
    check("to_en_off", outs(), ex(0, 4'd0, 3'd0, 0, 0));

    // Race: RESP in the same cycle timer reaches 15
    drive(1, 3'd2, 0, 0, 0, 0);
    step();
    for (int e = 1; e <= 15; e++) step();
    check("race_timer15", outs(), ex(1, 4'd1, 3'd2, 0, 0));
    drive(1, 3'd2, 0, 0, 4'd2, 1);
    step();
    check("race_resp_wins", outs(), ex(0, 4'd1, 3'd2, 1, 0));
    drive(0, 3'd2, 0, 0, 0, 0);
    step();

    // Abort mid-SEND_REQ, then fresh launch with a restarted timer
    drive(1, 3'd4, 0, 0, 0, 0);
    step();
    for (int e = 1; e <= 10; e++) step();
    drive(0, 3'd4, 0, 0, 0, 0);
    step();
    check("abort", outs(), ex(0, 4'd0, 3'd0, 0, 0));
    drive(1, 3'd1, 0, 0, 0, 0);
    step();
    check("restart_launch", outs(), ex(1, 4'd1, 3'd1, 0, 0));
    for (int e = 1; e <= 16; e++) begin
      step();
      if (e == 15) check("restart_no_early_to", outs(), ex(1, 4'd1, 3'd1, 0, 0));
      if (e == 16) check("restart_to", outs(), ex(0, 4'd1, 3'd1, 0, 1));
    end
    drive(0, 3'd1, 0, 0, 0, 0);
    step();

    // Async reset mid-handshake
    drive(1, 3'd3, 0, 0, 0, 0);
    step();
    check("pre_reset_launch", outs(), ex(1, 4'd1, 3'd3, 0, 0));
    #2 i_rst_n = 1'b0;
    #1 check("async_reset", outs(), ex(0, 4'd0, 3'd0, 0, 0));
    drive(0, 3'd3, 0, 0, 0, 0);
    #2 i_rst_n = 1'b1;
    step();
    check("post_reset_idle", outs(), ex(0, 4'd0, 3'd0, 0, 0));
    drive(1, 3'd3, 0, 0, 0, 0);
    step();
    check("post_reset_launch", outs(), ex(1, 4'd1, 3'd3, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
